// File: rtl/prog_loader_if.sv
// prog_loader_if: control, byte-stream and RAM-side signals of the program loader.
//   master : the environment (byte source, control unit, RAM/CPU observers)
//   slave  : the loader itself
// Signals:
//   start, abort        load control
//   in_data/in_valid    incoming byte stream, in_ready is the loader's accept
//   addr                RAM address while the loader is busy, 0 otherwise
//   ram_write/ram_read  RAM strobes (ram_read only toggles in the verify pass)
//   busy/cpu_hold       load in progress; CPU must stay off the bus and RAM
//   done/verify_err     completion and read-back checksum status
// The shared data bus is a tristate net and stays a plain inout port on the loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ram_write;
  logic                  ram_read;
  logic                  busy;
  logic                  cpu_hold;
  logic                  done;
  logic                  verify_err;

  modport master (
    output start, abort, in_data, in_valid,
    input  in_ready, addr, ram_write, ram_read, busy, cpu_hold, done, verify_err
  );

  modport slave (
    input  start, abort, in_data, in_valid,
    output in_ready, addr, ram_write, ram_read, busy, cpu_hold, done, verify_err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: copies LOAD_COUNT bytes from a valid/ready stream into RAM addresses
// 0..LOAD_COUNT-1, one byte per two cycles (accept in WAIT, strobe in WRITE), holding
// the CPU off the bus while busy.
// Ports:
//   i_clk    system clock, all state changes on posedge
//   i_reset  synchronous active-high reset
//   ld_if    prog_loader_if.slave (control, stream, RAM address/strobes, status)
//   io_bus   shared data bus, driven only while ram_write is high
// Optional feature: define LOADER_VERIFY_EN to add a read-back pass that sums the RAM
// contents over the bus and flags verify_err if the sum differs from the load checksum.
// Without it ram_read and verify_err are tied low.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOAD_COUNT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  prog_loader_if.slave          ld_if,
  inout  wire  [DATA_WIDTH-1:0] io_bus
);

  typedef enum logic [2:0] {StIdle, StWait, StWrite, StDone, StVerify} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(LOAD_COUNT - 1);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_csum;
  logic                  r_in_ready;
  logic                  r_ram_write;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_abort;
  logic                  w_ram_write;

`ifdef LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0] r_vcount;
  logic [DATA_WIDTH-1:0] r_vsum;
  logic [DATA_WIDTH-1:0] w_vsum_nxt;
  logic                  r_ram_read;
  logic                  r_verify_err;

  assign w_vsum_nxt = r_vsum + io_bus;
`endif

  // Abort only counts while a load is in progress.
  assign w_abort = ld_if.abort & r_busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_count      <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_csum       <= '0;
      r_in_ready   <= 1'b0;
      r_ram_write  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef LOADER_VERIFY_EN
      r_vcount     <= '0;
      r_vsum       <= '0;
      r_ram_read   <= 1'b0;
      r_verify_err <= 1'b0;
`endif
    end else if (w_abort) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_in_ready  <= 1'b0;
      r_ram_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef LOADER_VERIFY_EN
      r_ram_read  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (ld_if.start) begin
            r_state    <= StWait;
            r_count    <= '0;
            r_addr     <= '0;
            r_csum     <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
`ifdef LOADER_VERIFY_EN
            r_verify_err <= 1'b0;
`endif
          end
        end
        StWait: begin
          if (ld_if.in_valid) begin
            r_state     <= StWrite;
            r_data      <= ld_if.in_data;
            r_csum      <= r_csum + ld_if.in_data;
            r_in_ready  <= 1'b0;
            r_ram_write <= 1'b1;
          end
        end
        StWrite: begin
          r_ram_write <= 1'b0;
          if (r_count == LastIdx) begin
            r_addr <= '0;
`ifdef LOADER_VERIFY_EN
            r_state    <= StVerify;
            r_vcount   <= '0;
            r_vsum     <= '0;
            r_ram_read <= 1'b1;
`else
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else begin
            r_state    <= StWait;
            r_count    <= r_count + 1'b1;
            r_addr     <= r_count + 1'b1;
            r_in_ready <= 1'b1;
          end
        end
`ifdef LOADER_VERIFY_EN
        StVerify: begin
          r_vsum <= w_vsum_nxt;
          if (r_vcount == LastIdx) begin
            // Compare including the byte on the bus this cycle.
            r_verify_err <= (w_vsum_nxt != r_csum);
            r_state      <= StDone;
            r_addr       <= '0;
            r_ram_read   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_vcount <= r_vcount + 1'b1;
            r_addr   <= r_vcount + 1'b1;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  // Abort masks the strobes and the accept in its own cycle.
  assign w_ram_write     = r_ram_write & ~w_abort;
  assign ld_if.ram_write = w_ram_write;
  assign ld_if.in_ready  = r_in_ready & ~w_abort;
  assign ld_if.addr      = r_addr;
  assign ld_if.busy      = r_busy;
  assign ld_if.cpu_hold  = r_busy;
  assign ld_if.done      = r_done;
  assign io_bus          = w_ram_write ? r_data : {DATA_WIDTH{1'bz}};

`ifdef LOADER_VERIFY_EN
  assign ld_if.ram_read   = r_ram_read & ~w_abort;
  assign ld_if.verify_err = r_verify_err;
`else
  assign ld_if.ram_read   = 1'b0;
  assign ld_if.verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. Accepted bytes are pushed to a
// scoreboard queue with the address the loader must use; every RAM write strobe pops
// and compares address and bus data. A table drives a cycle-by-cycle handshake
// sequence; hand-written sequences cover full load, abort, start-while-busy and reset.
module tb_prog_loader;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LC = 16;
`ifdef LOADER_VERIFY_EN
  localparam int ExpDoneCyc = 48;
`else
  localparam int ExpDoneCyc = 32;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ram_clr = 1'b0;
  wire  [DW-1:0] bus;
  logic [DW-1:0] mem [LC];
  logic [DW-1:0] stream [LC];
  logic [11:0]   sb_q [$];
  logic [AW-1:0] mcnt = '0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            n_writes = 0;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lif ();

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_COUNT(LC)) u_dut (
    .i_clk  (clk),
    .i_reset(rst),
    .ld_if  (lif),
    .io_bus (bus)
  );

  // RAM model: asynchronous read onto the bus, write at posedge.
  assign bus = lif.ram_read ? mem[lif.addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < int'(LC); i++) mem[i] <= 8'hEE;
    end else if (lif.ram_write) begin
      mem[lif.addr] <= bus;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst && lif.in_valid && lif.in_ready) begin
      sb_q.push_back({mcnt, lif.in_data});
      mcnt = mcnt + 1'b1;
    end
    if (lif.ram_write) begin
      n_writes++;
      chk("rw_exclusive", 32'(lif.ram_read), 32'd0);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: write at addr %0d, required no write", lif.addr);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(lif.addr), 32'(e[11:8]));
        chk("wr_data", 32'(bus), 32'(e[7:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram();
    tick();
    ram_clr = 1'b1;
    tick();
    ram_clr = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(lif.in_ready), 32'd0);
    chk({tag, "_ram_write"}, 32'(lif.ram_write), 32'd0);
    chk({tag, "_ram_read"}, 32'(lif.ram_read), 32'd0);
    chk({tag, "_busy"}, 32'(lif.busy), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(lif.cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(lif.done), 32'd0);
    chk({tag, "_verify_err"}, 32'(lif.verify_err), 32'd0);
    chk({tag, "_addr"}, 32'(lif.addr), 32'd0);
  endtask

  // Starts a load and streams with in_valid held high. Cycle 0 is the first WAIT.
  // Returns at mid-cycle when done rises, or in the abort/reset cycle (those inputs
  // are left asserted so the next posedge samples them), or after the bound.
  task automatic run_load(input int abort_c, input int reset_c, input int start_c,
                          output int done_c);
    done_c = -1;
    tick();
    lif.start = 1'b1;
    mcnt = '0;
    #3;
    for (int c = 0; c < 100; c++) begin
      tick();
      lif.start    = (c == start_c);
      lif.abort    = (c == abort_c);
      rst          = (c == reset_c);
      lif.in_valid = 1'b1;
      lif.in_data  = c[0] ? 8'hFF : stream[(c / 2) % int'(LC)];
      #3;
      if (lif.done) begin
        done_c = c;
        break;
      end
      if (c == abort_c || c == reset_c) break;
    end
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic       valid;
    logic [7:0] data;
    logic       e_ready;
    logic       e_write;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_addr;
  } vec_t;

`ifdef LOADER_VERIFY_EN
  logic       rst4 = 1'b1;
  logic       poke_en = 1'b0;
  wire  [7:0] bus4;
  logic [7:0] mem4 [4];
  int         reads4 = 0;

  prog_loader_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) lif4 ();

  prog_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .LOAD_COUNT(4)) u_dut4 (
    .i_clk  (clk),
    .i_reset(rst4),
    .ld_if  (lif4),
    .io_bus (bus4)
  );

  assign bus4 = lif4.ram_read ? mem4[lif4.addr] : 8'hzz;
  always @(posedge clk) begin
    if (poke_en) mem4[2] <= 8'h07;
    else if (lif4.ram_write) mem4[lif4.addr] <= bus4;
  end
  always @(negedge clk) if (lif4.ram_read) reads4++;
`endif

  initial begin
    vec_t vt [13];
    int   dc;

    stream = '{8'h19, 8'h50, 8'h1F, 8'h30, 8'h24, 8'h70, 8'h00, 8'h8C,
               8'h41, 8'hD2, 8'h07, 8'hFE, 8'h63, 8'h9A, 8'h2B, 8'hC5};
    //            start ab val data  | rdy wr busy done addr
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h5E, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
    vt[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
    vt[11] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3};
    vt[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    lif.start    = 1'b0;
    lif.abort    = 1'b0;
    lif.in_valid = 1'b0;
    lif.in_data  = '0;
    tick();
    tick();
    #3;
    chk_reset("reset");
    tick();
    rst = 1'b0;

    // Handshake table: valid gaps, ignored valid in WRITE, start while busy, abort in WAIT.
    mcnt = '0;
    for (int i = 0; i < 13; i++) begin
      tick();
      lif.start    = vt[i].start;
      lif.abort    = vt[i].abort;
      lif.in_valid = vt[i].valid;
      lif.in_data  = vt[i].data;
      #3;
      chk($sformatf("v%0d_in_ready", i), 32'(lif.in_ready), 32'(vt[i].e_ready));
      chk($sformatf("v%0d_ram_write", i), 32'(lif.ram_write), 32'(vt[i].e_write));
      chk($sformatf("v%0d_busy", i), 32'(lif.busy), 32'(vt[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(lif.done), 32'(vt[i].e_done));
      chk($sformatf("v%0d_addr", i), 32'(lif.addr), 32'(vt[i].e_addr));
    end
    chk("table_sb_empty", 32'(sb_q.size()), 32'd0);

    // Full load with a start pulse in the WAIT of byte 3.
    clear_ram();
    n_writes = 0;
    run_load(-1, -1, 6, dc);
    chk("full_done_cycle", 32'(dc), 32'(ExpDoneCyc));
    chk("full_writes", 32'(n_writes), 32'd16);
    chk("full_done", 32'(lif.done), 32'd1);
    chk("full_busy", 32'(lif.busy), 32'd0);
    chk("full_verify_err", 32'(lif.verify_err), 32'd0);
    for (int i = 0; i < int'(LC); i++)
      chk($sformatf("full_mem%0d", i), 32'(mem[i]), 32'(stream[i]));
    tick();
    lif.in_valid = 1'b0;

    // Abort in the WRITE cycle of byte 5.
    clear_ram();
    n_writes = 0;
    run_load(11, -1, -1, dc);
    chk("abort_wr_masked", 32'(lif.ram_write), 32'd0);
    tick();
    lif.abort    = 1'b0;
    lif.in_valid = 1'b0;
    #3;
    chk("abort_busy", 32'(lif.busy), 32'd0);
    chk("abort_done", 32'(lif.done), 32'd0);
    chk("abort_in_ready", 32'(lif.in_ready), 32'd0);
    chk("abort_addr", 32'(lif.addr), 32'd0);
    chk("abort_writes", 32'(n_writes), 32'd5);
    chk("abort_stale_sb", 32'(sb_q.size()), 32'd1);
    sb_q.delete();
    for (int i = 0; i < 5; i++)
      chk($sformatf("abort_mem%0d", i), 32'(mem[i]), 32'(stream[i]));
    chk("abort_mem5", 32'(mem[5]), 32'hEE);

    // Reset in the WAIT of byte 7, then a clean reload from address 0.
    clear_ram();
    n_writes = 0;
    run_load(-1, 14, -1, dc);
    tick();
    rst          = 1'b0;
    lif.in_valid = 1'b0;
    #3;
    chk_reset("midrst");
    chk("midrst_writes", 32'(n_writes), 32'd7);
    sb_q.delete();
    n_writes = 0;
    run_load(-1, -1, -1, dc);
    chk("reload_done_cycle", 32'(dc), 32'(ExpDoneCyc));
    chk("reload_writes", 32'(n_writes), 32'd16);
    for (int i = 0; i < int'(LC); i++)
      chk($sformatf("reload_mem%0d", i), 32'(mem[i]), 32'(stream[i]));
    tick();
    lif.in_valid = 1'b0;

`ifdef LOADER_VERIFY_EN
    // Verify pass on a 4-byte image; second run corrupts addr 2 after its write.
    lif4.start = 1'b0;
    lif4.abort = 1'b0;
    lif4.in_valid = 1'b0;
    lif4.in_data = '0;
    tick();
    rst4 = 1'b0;
    for (int run = 0; run < 2; run++) begin
      int d4;
      d4 = -1;
      tick();
      lif4.start = 1'b1;
      #3;
      reads4 = 0;
      for (int c = 0; c < 40; c++) begin
        tick();
        lif4.start    = 1'b0;
        lif4.in_valid = 1'b1;
        lif4.in_data  = c[0] ? 8'hFF : 8'((c / 2) + 1);
        poke_en       = (run == 1) && (c == 6);
        #3;
        if (lif4.done) begin
          d4 = c;
          break;
        end
      end
      poke_en = 1'b0;
      chk($sformatf("ver%0d_done_cycle", run), 32'(d4), 32'd12);
      chk($sformatf("ver%0d_reads", run), 32'(reads4), 32'd4);
      chk($sformatf("ver%0d_done", run), 32'(lif4.done), 32'd1);
      chk($sformatf("ver%0d_err", run), 32'(lif4.verify_err), 32'(run));
      tick();
      lif4.in_valid = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
